// File: rtl/store_merge_ctrl_pkg.sv
// Purpose: shared types for the store sequencer (op codes, FSM states, latched request).
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Optional feature macro used by importers: STORE_LANE_SEL_EN.
package store_merge_pkg;

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } state_e;

    // Read-latency counter width; covers MEM_RD_LAT of 1..7.
    localparam int LAT_CNT_W = 3;

    // Request fields held stable for the whole store.
    typedef struct packed {
        op_e         op;
        logic [31:0] b_data;
    } req_t;

    // Misaligned accesses when lane selection is in use.
    function automatic logic lane_illegal(input op_e op, input logic [1:0] lane);
        return ((op == OP_SW) && (lane != 2'b00)) || ((op == OP_SH) && lane[0]);
    endfunction

endpackage

// File: rtl/store_merge_ctrl_if.sv
// Purpose: control-FSM request/response plus memory-port signals of the store sequencer.
// Latency: n/a (wires only).
// Backpressure: start is a one-cycle request; dropped unless the sequencer is idle.
// Ports: slave = sequencer side (start/op/addr/b_data/mem_rdata in; mem_addr/mem_wdata/
//        mem_wr/busy/done/err out); master = requester/memory side, opposite directions.
interface store_merge_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       b_data;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wr;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, op, addr, b_data, mem_rdata,
        output mem_addr, mem_wdata, mem_wr, busy, done, err
    );

    modport master (
        output start, op, addr, b_data, mem_rdata,
        input  mem_addr, mem_wdata, mem_wr, busy, done, err
    );
endinterface

// File: rtl/store_merge_ctrl_word_merge.sv
// Purpose: merge the store sub-word of b_data into a word read from memory.
// Latency: combinational.
// Backpressure: none.
// Ports: op (store kind), rd_word (old memory word), b_data (store source),
//        lane (byte lane; tie to 0 for low-sub-word merging), merged (result).
module store_word_merge
    import store_merge_pkg::*;
(
    input  op_e         op,
    input  logic [31:0] rd_word,
    input  logic [31:0] b_data,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);
    always_comb begin
        merged = rd_word;
        case (op)
            OP_SW: merged = b_data;
            OP_SH: begin
                if (lane[1]) merged[31:16] = b_data[15:0];
                else         merged[15:0]  = b_data[15:0];
            end
            OP_SB: begin
                case (lane)
                    2'd0:    merged[7:0]   = b_data[7:0];
                    2'd1:    merged[15:8]  = b_data[7:0];
                    2'd2:    merged[23:16] = b_data[7:0];
                    default: merged[31:24] = b_data[7:0];
                endcase
            end
            default: merged = rd_word;
        endcase
    end
endmodule

// File: rtl/store_merge_ctrl.sv
// Purpose: sequence SW (single write) and SH/SB (read-modify-write) stores to data memory.
// Latency: SW writes in cycle 1, done cycle 2; SH/SB write in cycle MEM_RD_LAT+1, done +2.
// Backpressure: start is accepted only in IDLE; starts while busy or in DONE are dropped.
// Ports: clk, reset (sync, active-high), bus (store_merge_ctrl_if.slave). All outputs registered.
// Macro STORE_LANE_SEL_EN: addr[1:0] picks the byte/half lane, mem_addr is word-aligned and
// misaligned SW/SH end in FAIL; when undefined, addr passes through and merges hit the low lane.
module store_merge_ctrl
    import store_merge_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic clk,
    input  logic reset,
    store_merge_ctrl_if.slave bus
);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_RD_LAT - 1);

    state_e                state;
    req_t                  req;
    logic [LAT_CNT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  mem_wr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    op_e                   op_in;
    logic                  start_fail;
    logic [ADDR_W-1:0]     start_addr;
    logic [1:0]            lane_sel;
    logic [31:0]           merged;

    assign op_in = op_e'(bus.op);

`ifdef STORE_LANE_SEL_EN
    logic [1:0] req_lane;

    assign start_fail = (op_in == OP_RSV) || lane_illegal(op_in, bus.addr[1:0]);
    assign start_addr = {bus.addr[ADDR_W-1:2], 2'b00};
    assign lane_sel   = req_lane;

    always_ff @(posedge clk) begin
        if (reset)                           req_lane <= 2'b00;
        else if (state == IDLE && bus.start) req_lane <= bus.addr[1:0];
    end
`else
    assign start_fail = (op_in == OP_RSV);
    assign start_addr = bus.addr;
    assign lane_sel   = 2'b00;
`endif

    // mem_rdata is merged on the last read-count cycle, so no separate rd_word register.
    store_word_merge u_merge (
        .op      (req.op),
        .rd_word (bus.mem_rdata),
        .b_data  (req.b_data),
        .lane    (lane_sel),
        .merged  (merged)
    );

    // Outputs are set on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req         <= '0;
            lat_cnt     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_wr_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        req     <= '{op: op_in, b_data: bus.b_data};
                        lat_cnt <= '0;
                        busy_q  <= 1'b1;
                        if (start_fail) begin
                            state  <= FAIL;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            mem_addr_q <= start_addr;
                            if (op_in == OP_SW) begin
                                state       <= WRITE;
                                mem_wr_q    <= 1'b1;
                                mem_wdata_q <= bus.b_data;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        state       <= WRITE;
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= merged;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE, FAIL: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_store_merge_ctrl.sv
// Purpose: self-checking bench for store_merge_ctrl with a latency-modelled word memory.
// Latency: DUT runs with MEM_RD_LAT = 3; read data is junk until the read has aged enough.
// Backpressure: stray starts while busy and in the done cycle must be dropped.
module tb_store_merge_ctrl;
    localparam int LAT = 3;
    localparam int AW  = 32;
`ifdef STORE_LANE_SEL_EN
    localparam bit LANE_EN = 1'b1;
`else
    localparam bit LANE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_merge_ctrl_if #(.ADDR_W(AW)) bus ();

    store_merge_ctrl #(.MEM_RD_LAT(LAT), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Standalone merge block, cross-checked against the arithmetic model.
    store_merge_pkg::op_e m_op;
    logic [31:0]          m_rd, m_b, m_out;
    logic [1:0]           m_lane;
    store_word_merge u_ref_merge (.op(m_op), .rd_word(m_rd), .b_data(m_b), .lane(m_lane), .merged(m_out));

    int n_cmp = 0;
    int n_bad = 0;

    // Memory: 256 words. Read data is only valid once the access has been outstanding
    // for LAT cycles counting the start cycle; before that it returns junk.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          age = 0;

    always @(posedge clk) age <= bus.busy ? age + 1 : 0;
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
    assign bus.mem_rdata = (bus.busy && age >= LAT - 1) ? mem[bus.mem_addr[9:2]] : 32'hBADC_0FFE;

    // Results of the most recent run_op.
    int          wr_cnt, wr_cyc, done_cyc;
    logic        err_seen;
    logic [31:0] last_wr_addr, last_wr_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store semantics by masks and shifts.
    function automatic logic [31:0] model_merge(input logic [1:0] o, input logic [31:0] w,
                                                input logic [31:0] b, input logic [1:0] lane);
        int          sh;
        logic [31:0] mask;
        case (o)
            2'b00:   return b;
            2'b01: begin
                sh   = 16 * int'(lane[1]);
                mask = 32'h0000_FFFF << sh;
                return (w & ~mask) | ((b & 32'h0000_FFFF) << sh);
            end
            2'b10: begin
                sh   = 8 * int'(lane);
                mask = 32'h0000_00FF << sh;
                return (w & ~mask) | ((b & 32'h0000_00FF) << sh);
            end
            default: return w;
        endcase
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a[9:2]]     = v;
        ref_mem[a[9:2]] = v;
    endtask

    // Called at a negedge; issues start in that cycle (cycle 0) and returns at a negedge
    // in the cycle after done, which is the earliest cycle a new start may be accepted.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit poke_busy, input bit poke_done);
        bit          exp_fail;
        logic [31:0] exp_addr, exp_dat;
        int          exp_wr, exp_done, busy_gap;
        logic [7:0]  idx;
        exp_fail = (o == 2'b11) ||
                   (LANE_EN && ((o == 2'b00 && a[1:0] != 2'b00) || (o == 2'b01 && a[0])));
        exp_addr = LANE_EN ? {a[31:2], 2'b00} : a;
        idx      = a[9:2];
        exp_dat  = model_merge(o, ref_mem[idx], b, LANE_EN ? a[1:0] : 2'b00);
        exp_wr   = (o == 2'b00) ? 1 : LAT + 1;
        exp_done = exp_fail ? 1 : exp_wr + 1;

        wr_cnt = 0; wr_cyc = 0; done_cyc = 0; err_seen = 1'b0; busy_gap = 0;
        bus.start = 1'b1; bus.op = o; bus.addr = a; bus.b_data = b;
        for (int c = 1; c <= 16 && done_cyc == 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.mem_wr) begin
                wr_cnt++; wr_cyc = c;
                last_wr_addr = bus.mem_addr; last_wr_dat = bus.mem_wdata;
            end
            if (!bus.busy) busy_gap++;
            if (bus.done) begin done_cyc = c; err_seen = bus.err; end
            // Inputs churn while busy; they must have been latched at acceptance.
            bus.op = 2'($urandom); bus.addr = $urandom; bus.b_data = $urandom;
            bus.start = (poke_busy && c == 1) || (poke_done && bus.done);
        end
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " idle_after_done"}, 32'(bus.busy), 32'd0);
        chk({tag, " done_cycle"}, done_cyc, exp_done);
        chk({tag, " err"}, 32'(err_seen), 32'(exp_fail));
        chk({tag, " busy_gaps"}, busy_gap, 0);
        chk({tag, " write_count"}, wr_cnt, exp_fail ? 0 : 1);
        if (!exp_fail) begin
            chk({tag, " write_cycle"}, wr_cyc, exp_wr);
            chk({tag, " write_addr"}, last_wr_addr, exp_addr);
            chk({tag, " write_data"}, last_wr_dat, exp_dat);
            chk({tag, " addr_hold"}, bus.mem_addr, exp_addr);
            ref_mem[idx] = exp_dat;
        end
        chk({tag, " mem_word"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rwr;
        logic [1:0]  o;
        logic [31:0] a, b, w;

        for (int i = 0; i < 256; i++) begin
            w = $urandom; mem[i] = w; ref_mem[i] = w;
        end
        reset = 1'b1; bus.start = 1'b0; bus.op = 2'b00; bus.addr = '0; bus.b_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst mem_addr",  bus.mem_addr, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst mem_wr",    32'(bus.mem_wr), 32'd0);
        chk("rst busy",      32'(bus.busy), 32'd0);
        chk("rst done",      32'(bus.done), 32'd0);
        chk("rst err",       32'(bus.err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed stores from the plan.
        run_op("sw", 2'b00, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("sw data const", last_wr_dat, 32'hDEAD_BEEF);
        preload(32'h80, 32'h1122_3344);
        run_op("sh", 2'b01, 32'h80, 32'hAAAA_5566, 1'b0, 1'b0);
        chk("sh data const", last_wr_dat, 32'h1122_5566);
        preload(32'h80, 32'h1122_3344);
        run_op("sb", 2'b10, 32'h80, 32'h0000_00FF, 1'b0, 1'b0);
        chk("sb data const", last_wr_dat, 32'h1122_33FF);
        run_op("rsv", 2'b11, 32'h40, 32'h1234_5678, 1'b0, 1'b0);
`ifdef STORE_LANE_SEL_EN
        preload(32'h80, 32'h1122_3344);
        run_op("sb lane2", 2'b10, 32'h82, 32'h0000_00EE, 1'b0, 1'b0);
        chk("sb lane2 data const", last_wr_dat, 32'h11EE_3344);
        chk("sb lane2 addr const", last_wr_addr, 32'h80);
        run_op("sh odd", 2'b01, 32'h81, 32'h0000_BBBB, 1'b0, 1'b0);
`endif
        // Second start while busy and a start in the done cycle must both be dropped.
        run_op("b2b", 2'b01, 32'h84, 32'hCAFE_F00D, 1'b1, 1'b1);

        // Reset during READ: no write may follow.
        bus.start = 1'b1; bus.op = 2'b10; bus.addr = 32'h88; bus.b_data = 32'h55;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rstmid busy", 32'(bus.busy), 32'd0);
        chk("rstmid mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rstmid done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        rwr = 0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (bus.mem_wr || bus.busy) rwr++;
        end
        chk("rstmid no_activity", rwr, 0);
        chk("rstmid mem_word", mem[8'h22], ref_mem[8'h22]);

        // Randomized stores, with the merge block cross-checked on the same operands.
        for (int k = 0; k < 40; k++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom_range(0, 1023);
            b = $urandom;
            m_op = store_merge_pkg::op_e'(o); m_rd = $urandom; m_b = b; m_lane = a[1:0];
            #1;
            chk("merge unit", m_out, model_merge(o, m_rd, b, a[1:0]));
            run_op("rand", o, a, b, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
